// File: rtl/stego_pkg.sv
// Shared types and helpers for the output word packer.
// Optional feature macro: STEGO_PACK_CHECKSUM_EN (see out_word_packer.sv).
package stego_pkg;

    localparam int BYTE_W     = 8;
    localparam int LANES      = 4;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int FILL_W     = LANE_IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        WRITE,
        DONE
    } state_e;

    // Write-enable mask for a word holding 'fill' bytes, lowest lanes first.
    function automatic logic [LANES-1:0] tail_mask(input logic [FILL_W-1:0] fill);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (FILL_W'(i) < fill);
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_pack_reg.sv
// Four-lane byte accumulator: bytes land in lane order, the fill count
// gives both the next lane index and the write-enable mask.
module lane_pack_reg
    import stego_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        wr_en_i,
    input  logic [BYTE_W-1:0]           wr_data_i,
    output logic [LANES*BYTE_W-1:0]     word_o,
    output logic [LANE_IDX_W-1:0]       idx_o,
    output logic [LANES-1:0]            mask_o
);

    logic [LANES-1:0][BYTE_W-1:0] lane_q;
    logic [FILL_W-1:0]            fill_q;

    // Capture one byte into the next free lane; clear empties all lanes so
    // unfilled lanes of a partial word read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            fill_q <= '0;
        end else if (wr_en_i) begin
            lane_q[fill_q[LANE_IDX_W-1:0]] <= wr_data_i;
            fill_q                         <= fill_q + FILL_W'(1);
        end
    end

    assign word_o = lane_q;
    assign idx_o  = fill_q[LANE_IDX_W-1:0];
    assign mask_o = tail_mask(fill_q);

endmodule

// File: rtl/out_word_packer.sv
// Drains result bytes from the output FIFO, packs them four per word and
// writes them to the image or secret BRAM port chosen at launch.
// Optional: define STEGO_PACK_CHECKSUM_EN to add a running byte checksum output.
module out_word_packer
    import stego_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int REG_WIDTH  = 32,
    parameter int FF_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sel,
    input  logic [REG_WIDTH-1:0]  data_size,
    input  logic                  ff_empty,
    input  logic [FF_WIDTH-1:0]   ff_rd_data,
    output logic                  ff_rden,
    output logic                  image_clk,
    output logic [DATA_WIDTH-1:0] image_wrdata,
    output logic [ADDR_WIDTH-1:0] image_addr,
    output logic [NUM_BYTES-1:0]  image_we,
    output logic                  secret_clk,
    output logic [DATA_WIDTH-1:0] secret_wrdata,
    output logic [ADDR_WIDTH-1:0] secret_addr,
    output logic [NUM_BYTES-1:0]  secret_we,
    output logic                  finish
`ifdef STEGO_PACK_CHECKSUM_EN
    ,
    output logic [REG_WIDTH-1:0]  checksum
`endif
);

    state_e                  state_q;
    logic                    sel_q;
    logic [REG_WIDTH-1:0]    size_q;
    logic [REG_WIDTH-1:0]    cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    finish_q;

    logic                    launch;
    logic                    wr_active;
    logic [LANES*BYTE_W-1:0] word;
    logic [LANE_IDX_W-1:0]   lane_idx;
    logic [LANES-1:0]        fill_mask;

    assign launch    = (state_q == IDLE) && start;
    assign wr_active = (state_q == WRITE);

    lane_pack_reg u_lanes (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wr_active || launch),
        .wr_en_i   (state_q == CAPT),
        .wr_data_i (ff_rd_data),
        .word_o    (word),
        .idx_o     (lane_idx),
        .mask_o    (fill_mask)
    );

    // Control FSM: launch, fetch/capture byte pairs, word writes, completion hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            size_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q   <= sel;
                        size_q  <= data_size;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        state_q <= (data_size == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (!ff_empty) state_q <= CAPT;
                end
                CAPT: begin
                    cnt_q <= cnt_q + REG_WIDTH'(1);
                    if (lane_idx == LANE_IDX_W'(LANES - 1) ||
                        cnt_q + REG_WIDTH'(1) == size_q)
                        state_q <= WRITE;
                    else
                        state_q <= FETCH;
                end
                WRITE: begin
                    addr_q  <= addr_q + ADDR_WIDTH'(NUM_BYTES);
                    state_q <= (cnt_q == size_q) ? DONE : FETCH;
                end
                DONE: begin
                    // finish is shown for at least one cycle even if start already fell
                    finish_q <= 1'b1;
                    if (!start && finish_q) begin
                        finish_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The pop must be combinational so the FIFO presents the byte during CAPT.
    assign ff_rden = (state_q == FETCH) && !ff_empty;
    assign finish  = finish_q;

    assign image_clk     = clk;
    assign secret_clk    = clk;
    assign image_addr    = addr_q;
    assign secret_addr   = addr_q;
    assign image_we      = (wr_active && !sel_q) ? NUM_BYTES'(fill_mask) : '0;
    assign secret_we     = (wr_active &&  sel_q) ? NUM_BYTES'(fill_mask) : '0;
    assign image_wrdata  = (wr_active && !sel_q) ? DATA_WIDTH'(word) : '0;
    assign secret_wrdata = (wr_active &&  sel_q) ? DATA_WIDTH'(word) : '0;

`ifdef STEGO_PACK_CHECKSUM_EN
    logic [REG_WIDTH-1:0] checksum_q;

    // Sum every captured byte; all captured bytes are written, so this is the written sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum_q <= '0;
        else if (launch)
            checksum_q <= '0;
        else if (state_q == CAPT)
            checksum_q <= checksum_q + REG_WIDTH'(ff_rd_data);
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_out_word_packer.sv
// Directed bench for out_word_packer with a small FIFO model and write monitor.
module tb_out_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [31:0] data_size;
    logic        ff_empty;
    logic [7:0]  ff_rd_data;
    logic        ff_rden;
    logic        image_clk, secret_clk;
    logic [31:0] image_wrdata, secret_wrdata;
    logic [31:0] image_addr, secret_addr;
    logic [3:0]  image_we, secret_we;
    logic        finish;
`ifdef STEGO_PACK_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    out_word_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sel           (sel),
        .data_size     (data_size),
        .ff_empty      (ff_empty),
        .ff_rd_data    (ff_rd_data),
        .ff_rden       (ff_rden),
        .image_clk     (image_clk),
        .image_wrdata  (image_wrdata),
        .image_addr    (image_addr),
        .image_we      (image_we),
        .secret_clk    (secret_clk),
        .secret_wrdata (secret_wrdata),
        .secret_addr   (secret_addr),
        .secret_we     (secret_we),
        .finish        (finish)
`ifdef STEGO_PACK_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: initial block owns the write side, this process the read side.
    logic [7:0] fifo_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         bad_rden = 0;

    assign ff_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (ff_rden) begin
            if (rd_ptr == wr_ptr) bad_rden <= bad_rden + 1;
            else begin
                ff_rd_data <= fifo_mem[rd_ptr[5:0]];
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    // Write monitor: log every BRAM write seen on either port.
    int          n_wr = 0;
    int          n_both = 0;
    logic        log_port [0:31];
    logic [31:0] log_addr [0:31];
    logic [31:0] log_data [0:31];
    logic [3:0]  log_we   [0:31];
    int          log_cyc  [0:31];

    always @(negedge clk) begin
        if (image_we != 4'h0 || secret_we != 4'h0) begin
            log_port[n_wr[4:0]] <= (secret_we != 4'h0);
            log_addr[n_wr[4:0]] <= (secret_we != 4'h0) ? secret_addr   : image_addr;
            log_data[n_wr[4:0]] <= (secret_we != 4'h0) ? secret_wrdata : image_wrdata;
            log_we[n_wr[4:0]]   <= (secret_we != 4'h0) ? secret_we     : image_we;
            log_cyc[n_wr[4:0]]  <= cyc;
            n_wr                <= n_wr + 1;
            if (image_we != 4'h0 && secret_we != 4'h0) n_both <= n_both + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic port,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        chk({tag, ".port"}, 64'(log_port[idx[4:0]]), 64'(port));
        chk({tag, ".addr"}, 64'(log_addr[idx[4:0]]), 64'(addr));
        chk({tag, ".data"}, 64'(log_data[idx[4:0]]), 64'(data));
        chk({tag, ".we"},   64'(log_we[idx[4:0]]),   64'(we));
    endtask

    int launch_cyc;

    // Launch a run and wait (bounded) for finish; optionally keep start high.
    task automatic run(input logic s, input logic [31:0] n, input bit hold);
        int k;
        sel        = s;
        data_size  = n;
        start      = 1'b1;
        launch_cyc = cyc;
        k = 0;
        while (!finish && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("finish_timeout", 64'(k < 2000), 64'd1);
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int base, pbase, k;
        rst_n     = 1'b0;
        start     = 1'b0;
        sel       = 1'b0;
        data_size = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst.finish",   64'(finish),     64'd0);
        chk("rst.ff_rden",  64'(ff_rden),    64'd0);
        chk("rst.image_we", 64'(image_we),   64'd0);
        chk("rst.secret_we",64'(secret_we),  64'd0);
        chk("rst.addr",     64'(image_addr), 64'd0);
        chk("rst.wrdata",   64'(image_wrdata), 64'd0);
`ifdef STEGO_PACK_CHECKSUM_EN
        chk("rst.checksum", 64'(checksum),   64'd0);
`endif

        // 8 bytes to image port
        base = n_wr; pbase = rd_ptr;
        for (int i = 1; i <= 8; i++) push(8'(i));
        run(1'b0, 32'd8, 1'b0);
        chk("t1.nwr",  64'(n_wr - base),    64'd2);
        chk("t1.pops", 64'(rd_ptr - pbase), 64'd8);
        chk_wr("t1.w0", base,     1'b0, 32'd0, 32'h04030201, 4'hF);
        chk_wr("t1.w1", base + 1, 1'b0, 32'd4, 32'h08070605, 4'hF);
        chk("t1.lat",  64'((log_cyc[base[4:0]] - launch_cyc) >= 8), 64'd1);
        chk("t1.finish_low", 64'(finish), 64'd0);

        // 6 bytes to secret port, partial tail
        base = n_wr; pbase = rd_ptr;
        for (int i = 0; i < 6; i++) push(8'hAA + 8'(i));
        run(1'b1, 32'd6, 1'b0);
        chk("t2.nwr",  64'(n_wr - base),    64'd2);
        chk("t2.pops", 64'(rd_ptr - pbase), 64'd6);
        chk_wr("t2.w0", base,     1'b1, 32'd0, 32'hADACABAA, 4'hF);
        chk_wr("t2.w1", base + 1, 1'b1, 32'd4, 32'h0000AFAE, 4'h3);

        // size 0: finish two cycles after start, no pop, no write
        base = n_wr; pbase = rd_ptr;
        push(8'h55);
        sel = 1'b0; data_size = 32'd0; start = 1'b1;
        k = 0;
        while (!finish && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t3.lat",  64'(k), 64'd2);
        chk("t3.pops", 64'(rd_ptr - pbase), 64'd0);
        chk("t3.nwr",  64'(n_wr - base),    64'd0);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t3.finish_low", 64'(finish), 64'd0);
        // consume the leftover byte so it does not skew the next run
        base = n_wr; pbase = rd_ptr;
        run(1'b0, 32'd1, 1'b0);
        chk_wr("t3.left", base, 1'b0, 32'd0, 32'h00000055, 4'h1);

        // FIFO runs dry mid-word
        base = n_wr; pbase = rd_ptr;
        push(8'h10); push(8'h11);
        sel = 1'b0; data_size = 32'd4; start = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4.pops_stall", 64'(rd_ptr - pbase), 64'd2);
        chk("t4.nwr_stall",  64'(n_wr - base),    64'd0);
        chk("t4.rden_stall", 64'(ff_rden),        64'd0);
        chk("t4.fin_stall",  64'(finish),         64'd0);
        push(8'h12); push(8'h13);
        run(1'b0, 32'd4, 1'b0);
        chk("t4.nwr", 64'(n_wr - base), 64'd1);
        chk_wr("t4.w0", base, 1'b0, 32'd0, 32'h13121110, 4'hF);

        // reset during second word write, then restart from address 0
        for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
        sel = 1'b0; data_size = 32'd8; start = 1'b1;
        k = 0;
        while (!(image_we != 4'h0 && image_addr == 32'd4) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5.reach_w1", 64'(k < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5.we",     64'(image_we), 64'd0);
        chk("t5.finish", 64'(finish),   64'd0);
        chk("t5.rden",   64'(ff_rden),  64'd0);
        chk("t5.addr",   64'(image_addr), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = n_wr;
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        run(1'b0, 32'd4, 1'b0);
        chk("t5.nwr", 64'(n_wr - base), 64'd1);
        chk_wr("t5.w0", base, 1'b0, 32'd0, 32'h34333231, 4'hF);

        // 5 x FF, single-byte tail, start held high in DONE
        base = n_wr;
        for (int i = 0; i < 5; i++) push(8'hFF);
        run(1'b0, 32'd5, 1'b1);
        chk_wr("t6.w0", base,     1'b0, 32'd0, 32'hFFFFFFFF, 4'hF);
        chk_wr("t6.w1", base + 1, 1'b0, 32'd4, 32'h000000FF, 4'h1);
`ifdef STEGO_PACK_CHECKSUM_EN
        chk("t6.checksum", 64'(checksum), 64'h4FB);
`endif
        repeat (5) @(negedge clk);
        chk("t6.hold_finish", 64'(finish),      64'd1);
        chk("t6.hold_nwr",    64'(n_wr - base), 64'd2);
`ifdef STEGO_PACK_CHECKSUM_EN
        chk("t6.hold_checksum", 64'(checksum), 64'h4FB);
`endif
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t6.finish_low", 64'(finish), 64'd0);

        // global invariants
        chk("never_both_we",   64'(n_both),   64'd0);
        chk("no_pop_on_empty", 64'(bad_rden), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
